n64adv2_spdif_encoder: RTL and testbench
========================================

N64ADV2_SPDIF_ENCODER -- requirements
Module: n64adv2_spdif_encoder

Interface
REQ-001 SHALL have parameter HALFBIT_DIV, default 2, meaning MCLK cycles per BMC half-bit (2 -> 12.288 MHz MCLK yields 48 kHz frames).
REQ-002 SHALL have port MCLK_i, input, 1, the single clock; all logic is in this domain.
REQ-003 SHALL have port nRST_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port PDATA_LEFT_i, input, 24, signed left sample.
REQ-005 SHALL have port PDATA_RIGHT_i, input, 24, signed right sample.
REQ-006 SHALL have port PDATA_VALID_i, input, 1, one-cycle strobe qualifying both samples.
REQ-007 SHALL have port SPDIF_en, input, 1, encoder enable.
REQ-008 SHALL have port SPDIF_o, output, 1, IEC 60958 biphase-mark stream.
REQ-009 SHALL have port FRAME_START_o, output, 1, one-cycle pulse when a frame's left-subframe preamble begins.
REQ-010 SHALL have port UNDERRUN_o, output, 1, one-cycle pulse when a frame starts with no new sample pair received.

Function
REQ-011 SHALL capture PDATA_LEFT_i/PDATA_RIGHT_i into a holding pair and set a pending flag on every cycle PDATA_VALID_i=1; a later strobe before consumption overwrites the pair.
REQ-012 SHALL generate a half-bit tick every HALFBIT_DIV cycles from a counter; 64 half-bits per subframe, 128 per frame.
REQ-013 SHALL, at the first half-bit of each frame, copy the holding pair into the transmit pair and clear pending; if pending was 0, retransmit the previous pair and pulse UNDERRUN_o.
REQ-014 SHALL, if PDATA_VALID_i coincides with the frame-start load cycle, transmit the old holding pair and keep the new pair pending.
REQ-015 SHALL use a subframe of 32 slots: 0-3 preamble, 4-27 audio LSB first (bit 0 in slot 4), 28 V=0, 29 U=0, 30 C, 31 P.
REQ-016 SHALL send left subframe first, then right, with the transmit pair fixed for the whole frame.
REQ-017 SHALL choose preamble B for left of frame 0, M for left of frames 1-191, W for every right subframe.
REQ-018 SHALL drive preamble half-bits B=11101000, M=11100010, W=11100100 when the preceding half-bit level was 0, and their bitwise inverse when it was 1.
REQ-019 SHALL encode slots 4-31 in biphase mark: toggle level at slot start; toggle again mid-slot iff the bit is 1.
REQ-020 SHALL set P so that slots 4-31 contain an even number of ones.
REQ-021 SHALL take C from a fixed 192-bit consumer channel-status word indexed by frame number (0-191): ones at bits 2, 25, 32, 33, 35, zeros elsewhere, identical in both subframes.
REQ-022 SHALL wrap the frame counter from 191 to 0, so the next left subframe uses preamble B.
REQ-023 SHALL, while SPDIF_en=0, hold SPDIF_o=0, frame counter=0, slot/half-bit counters=0, no pulses; holding-register capture continues.
REQ-024 SHALL, on SPDIF_en 0->1, start a frame with preamble B on the first following half-bit tick, with previous level taken as 0.
REQ-025 SHALL, on SPDIF_en 1->0 mid-frame, force SPDIF_o=0 on the next cycle, abandoning the frame.
REQ-026 SHALL register SPDIF_o directly from a flop, glitch-free, changing only on half-bit ticks while enabled.

Reset
REQ-027 SHALL on nRST_i=0 asynchronously clear SPDIF_o, FRAME_START_o, UNDERRUN_o, pending flag, holding/transmit pairs, all counters and the previous-level register to 0.
REQ-028 SHALL after reset release with SPDIF_en=1 begin frame 0 with preamble B pattern 11101000 on the first half-bit tick.

Verification
REQ-029 Enable, feed L=0x000001, R=0x800000 once per 256 cycles -> left subframe slots 4-27 = 1 then 23 zeros, P=1; right slot 27=1, P=1; no UNDERRUN_o.
REQ-030 Run 193 frames -> FRAME_START_o every 256 cycles; B at frames 0 and 192, M otherwise; C bits decoded over 192 frames = 1 exactly at 2, 25, 32, 33, 35.
REQ-031 Stop PDATA_VALID_i after frame 3 -> UNDERRUN_o pulses at frame 4 start; frame 4 repeats frame 3 samples.
REQ-032 PDATA_VALID_i on the frame-start load cycle with L=0x123456 -> current frame sends old pair; next frame sends 0x123456.
REQ-033 Deassert SPDIF_en at half-bit 40, reassert 100 cycles later -> SPDIF_o=0 next cycle and while disabled; restart with B, counter 0.
REQ-034 Assert nRST_i=0 mid-subframe -> all outputs 0 immediately; after release stream restarts at frame 0 per REQ-028.

Source files
------------

// File: rtl/n64adv2_spdif_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : n64adv2_spdif_encoder                                      |
// | Description : IEC 60958 consumer S/PDIF transmitter. Packs a 24-bit      |
// |               stereo sample pair into one 128-half-bit frame and drives  |
// |               it out as a biphase-mark coded stream.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module n64adv2_spdif_encoder #(
   parameter int HALFBIT_DIV = 2
) (
   input  logic        MCLK_i,
   input  logic        nRST_i,
   input  logic [23:0] PDATA_LEFT_i,
   input  logic [23:0] PDATA_RIGHT_i,
   input  logic        PDATA_VALID_i,
   input  logic        SPDIF_en,
   output logic        SPDIF_o,
   output logic        FRAME_START_o,
   output logic        UNDERRUN_o
);

   localparam int         DIV_W     = (HALFBIT_DIV > 1) ? $clog2(HALFBIT_DIV) : 1;
   localparam logic [7:0] PRE_B     = 8'b11101000;
   localparam logic [7:0] PRE_M     = 8'b11100010;
   localparam logic [7:0] PRE_W     = 8'b11100100;
   localparam logic [7:0] LAST_FRM  = 8'd191;

   logic [DIV_W-1:0] div_cnt;
   logic [6:0]       hb_cnt;      // [6] = subframe, [5:1] = slot, [0] = half
   logic [7:0]       frame_cnt;
   logic [23:0]      hold_l, hold_r, tx_l, tx_r;
   logic             pending;
   logic             prev_lvl;    // level seen just before the current preamble

   logic             tick;
   logic             frame_load;
   logic [4:0]       slot;
   logic [4:0]       bit_idx;
   logic [23:0]      sample;
   logic [7:0]       pattern;
   logic             c_bit;
   logic             data_bit;
   logic             pre_inv;
   logic             next_lvl;

   // The first enabled cycle is a tick so a restart begins without delay.
   assign tick       = SPDIF_en && (div_cnt == '0);
   assign frame_load = tick && (hb_cnt == 7'd0);
   assign slot       = hb_cnt[5:1];
   assign bit_idx    = slot - 5'd4;

   // Half-bit prescaler, parked at zero while disabled.
   always_ff @(posedge MCLK_i or negedge nRST_i) begin
      if (!nRST_i)
         div_cnt <= '0;
      else if (!SPDIF_en || (div_cnt == DIV_W'(HALFBIT_DIV - 1)))
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   // Half-bit position within the frame and channel-status frame index.
   always_ff @(posedge MCLK_i or negedge nRST_i) begin
      if (!nRST_i) begin
         hb_cnt    <= '0;
         frame_cnt <= '0;
      end else if (!SPDIF_en) begin
         hb_cnt    <= '0;
         frame_cnt <= '0;
      end else if (tick) begin
         hb_cnt <= hb_cnt + 7'd1;
         if (hb_cnt == 7'd127)
            frame_cnt <= (frame_cnt == LAST_FRM) ? 8'd0 : frame_cnt + 8'd1;
      end
   end

   // Sample holding pair; a strobe on the load cycle wins over the clear.
   always_ff @(posedge MCLK_i or negedge nRST_i) begin
      if (!nRST_i) begin
         hold_l  <= '0;
         hold_r  <= '0;
         pending <= 1'b0;
      end else if (PDATA_VALID_i) begin
         hold_l  <= PDATA_LEFT_i;
         hold_r  <= PDATA_RIGHT_i;
         pending <= 1'b1;
      end else if (frame_load) begin
         pending <= 1'b0;
      end
   end

   // Transmit pair, refreshed only at frame start when new data is waiting.
   always_ff @(posedge MCLK_i or negedge nRST_i) begin
      if (!nRST_i) begin
         tx_l <= '0;
         tx_r <= '0;
      end else if (frame_load && pending) begin
         tx_l <= hold_l;
         tx_r <= hold_r;
      end
   end

   // Level of the half-bit about to be sent.
   always_comb begin
      sample   = hb_cnt[6] ? tx_r : tx_l;
      c_bit    = (frame_cnt == 8'd2)  || (frame_cnt == 8'd25) || (frame_cnt == 8'd32) ||
                 (frame_cnt == 8'd33) || (frame_cnt == 8'd35);
      data_bit = 1'b0;
      if (slot <= 5'd27 && slot >= 5'd4)
         data_bit = sample[bit_idx];
      else if (slot == 5'd30)
         data_bit = c_bit;
      else if (slot == 5'd31)
         data_bit = (^sample) ^ c_bit;

      if (hb_cnt[6])
         pattern = PRE_W;
      else if (frame_cnt == 8'd0)
         pattern = PRE_B;
      else
         pattern = PRE_M;
      pre_inv = (hb_cnt[5:0] == 6'd0) ? SPDIF_o : prev_lvl;

      if (hb_cnt[5:3] == 3'd0)
         next_lvl = pattern[3'd7 - hb_cnt[2:0]] ^ pre_inv;
      else if (hb_cnt[0])
         next_lvl = SPDIF_o ^ data_bit;
      else
         next_lvl = ~SPDIF_o;
   end

   // Output flops: line level, preamble polarity and status pulses.
   always_ff @(posedge MCLK_i or negedge nRST_i) begin
      if (!nRST_i) begin
         SPDIF_o       <= 1'b0;
         prev_lvl      <= 1'b0;
         FRAME_START_o <= 1'b0;
         UNDERRUN_o    <= 1'b0;
      end else if (!SPDIF_en) begin
         SPDIF_o       <= 1'b0;
         prev_lvl      <= 1'b0;
         FRAME_START_o <= 1'b0;
         UNDERRUN_o    <= 1'b0;
      end else begin
         FRAME_START_o <= frame_load;
         UNDERRUN_o    <= frame_load && !pending;
         if (tick) begin
            SPDIF_o <= next_lvl;
            if (hb_cnt[5:0] == 6'd0)
               prev_lvl <= SPDIF_o;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_n64adv2_spdif_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_n64adv2_spdif_encoder                                   |
// | Description : Self-checking bench; a frame-level model builds the        |
// |               expected half-bit stream of each frame from the sample     |
// |               pair and frame number.                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_n64adv2_spdif_encoder;

   localparam int DIV       = 2;
   localparam int FRAME_CYC = 128 * DIV;

   logic        clk;
   logic        nrst;
   logic [23:0] pdata_l, pdata_r;
   logic        pdata_v;
   logic        en;
   logic        spdif, fstart, urun;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic        exp_hb [0:127];
   logic [23:0] m_hl, m_hr, m_txl, m_txr;
   logic        m_pend, m_lvl;
   int          m_fpos, m_fnum;
   logic [7:0]  cap;

   n64adv2_spdif_encoder #(.HALFBIT_DIV(DIV)) dut (
      .MCLK_i        (clk),
      .nRST_i        (nrst),
      .PDATA_LEFT_i  (pdata_l),
      .PDATA_RIGHT_i (pdata_r),
      .PDATA_VALID_i (pdata_v),
      .SPDIF_en      (en),
      .SPDIF_o       (spdif),
      .FRAME_START_o (fstart),
      .UNDERRUN_o    (urun)
   );

   // free-running clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Whole frame as a list of half-bit levels, starting from line level lvl0.
   task automatic build_frame(input logic [23:0] l, input logic [23:0] r,
                              input int fn, input logic lvl0);
      logic       lvl, b, cb;
      logic [7:0] pat;
      logic [23:0] d;
      int k, ones;
      lvl = lvl0;
      k   = 0;
      cb  = (fn == 2) || (fn == 25) || (fn == 32) || (fn == 33) || (fn == 35);
      for (int sub = 0; sub < 2; sub++) begin
         if (sub == 1)     pat = 8'b11100100;
         else if (fn == 0) pat = 8'b11101000;
         else              pat = 8'b11100010;
         if (lvl) pat = ~pat;
         for (int i = 7; i >= 0; i--) begin
            exp_hb[k] = pat[i];
            k++;
         end
         lvl  = pat[0];
         d    = (sub == 1) ? r : l;
         ones = int'(cb);
         for (int i = 0; i < 24; i++) ones += int'(d[i]);
         for (int s = 4; s < 32; s++) begin
            if (s < 28)       b = d[s-4];
            else if (s == 30) b = cb;
            else if (s == 31) b = ones[0];
            else              b = 1'b0;
            lvl = ~lvl;
            exp_hb[k] = lvl;
            k++;
            if (b) lvl = ~lvl;
            exp_hb[k] = lvl;
            k++;
         end
      end
   endtask

   task automatic model_reset();
      m_hl = '0; m_hr = '0; m_txl = '0; m_txr = '0;
      m_pend = 1'b0; m_lvl = 1'b0; m_fpos = 0; m_fnum = 0;
   endtask

   // One clock: drive inputs, predict, then compare just after the edge.
   task automatic step(input logic v, input logic [23:0] l, input logic [23:0] r);
      logic e_s, e_fs, e_ur;
      pdata_v = v; pdata_l = l; pdata_r = r;
      e_s = 1'b0; e_fs = 1'b0; e_ur = 1'b0;
      if (!en) begin
         m_fpos = 0;
         m_fnum = 0;
      end else begin
         if (m_fpos == 0) begin
            e_fs = 1'b1;
            if (m_pend) begin
               m_txl = m_hl; m_txr = m_hr; m_pend = 1'b0;
            end else begin
               e_ur = 1'b1;
            end
            build_frame(m_txl, m_txr, m_fnum, m_lvl);
         end
         e_s = exp_hb[m_fpos / DIV];
         m_fpos++;
         if (m_fpos == FRAME_CYC) begin
            m_fpos = 0;
            m_fnum = (m_fnum + 1) % 192;
         end
      end
      if (v) begin
         m_hl = l; m_hr = r; m_pend = 1'b1;
      end
      m_lvl = e_s;
      @(posedge clk); #1;
      chk("spdif",       32'(spdif),  32'(e_s));
      chk("frame_start", 32'(fstart), 32'(e_fs));
      chk("underrun",    32'(urun),   32'(e_ur));
   endtask

   // One frame; optional strobe at a given offset; first preamble captured.
   task automatic run_frame(input logic send, input int offset,
                            input logic [23:0] l, input logic [23:0] r);
      for (int c = 0; c < FRAME_CYC; c++) begin
         step(send && (c == offset), l, r);
         if (c < 16 && (c % 2) == 0) cap = {cap[6:0], spdif};
      end
   endtask

   initial begin
      clk = 0; nrst = 0; en = 0; pdata_v = 0; pdata_l = '0; pdata_r = '0;
      cap = '0;
      model_reset();

      // reset state
      #12;
      chk("rst_spdif", 32'(spdif), 32'd0);
      chk("rst_fs",    32'(fstart), 32'd0);
      chk("rst_ur",    32'(urun),   32'd0);
      @(negedge clk);
      nrst = 1;

      // disabled: capture continues, line idle
      step(1'b0, '0, '0);
      step(1'b1, 24'h000001, 24'h800000);
      step(1'b0, '0, '0);

      // directed pair, frames 0 and 1
      en = 1;
      run_frame(1'b1, 100, 24'h000001, 24'h800000);
      chk("preamble_B_start", 32'(cap), 32'h000000E8);
      run_frame(1'b1, 37, 24'h000001, 24'h800000);
      run_frame(1'b1, 200, 24'($urandom), 24'($urandom));
      // no data in frame 3 -> underrun at frame 4, repeat of frame 3 pair
      run_frame(1'b0, 0, '0, '0);
      run_frame(1'b1, 90, 24'($urandom), 24'($urandom));
      // strobe on the load cycle: old pair now, 0x123456 next frame
      run_frame(1'b1, 0, 24'h123456, 24'h654321);
      run_frame(1'b0, 0, '0, '0);

      // remaining frames through the 191 -> 0 wrap (frame 192 uses B)
      for (int f = 7; f < 193; f++) begin
         run_frame(($urandom_range(0, 15) != 0), $urandom_range(0, FRAME_CYC - 1),
                   24'($urandom), 24'($urandom));
      end

      // disable at half-bit 40, then restart
      for (int c = 0; c < 40 * DIV; c++) step(1'b0, '0, '0);
      en = 0;
      for (int c = 0; c < 100; c++) step((c == 50), 24'($urandom), 24'($urandom));
      en = 1;
      run_frame(1'b1, 120, 24'($urandom), 24'($urandom));
      chk("preamble_B_reenable", 32'(cap), 32'h000000E8);

      // asynchronous reset in the middle of the left subframe
      for (int c = 0; c < 44; c++) step(1'b0, '0, '0);
      #3 nrst = 0;
      #1;
      chk("async_rst_spdif", 32'(spdif), 32'd0);
      chk("async_rst_fs",    32'(fstart), 32'd0);
      chk("async_rst_ur",    32'(urun),   32'd0);
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      chk("held_rst_spdif", 32'(spdif), 32'd0);
      nrst = 1;
      run_frame(1'b1, 60, 24'($urandom), 24'($urandom));
      chk("preamble_B_after_rst", 32'(cap), 32'h000000E8);
      run_frame(1'b1, 10, 24'($urandom), 24'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
